// File: rtl/mutex_arb.sv
// mutex_arb: two-requester mutual-exclusion arbiter with round-robin tie break,
// per-requester grant counters and an optional hold timeout (MUTEX_TIMEOUT_EN).
module mutex_arb #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    output logic             grant0,
    output logic             grant1,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1,
    output logic             timeout_evt
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] gcnt0_q, gcnt0_d;
    logic [CNT_W-1:0] gcnt1_q, gcnt1_d;
    logic             mine, other;
`ifdef MUTEX_TIMEOUT_EN
    localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    // Next state: arbitrate from IDLE, hold or hand off from a grant state,
    // and bump owner/counter on every entry into a grant state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
`ifdef MUTEX_TIMEOUT_EN
        hold_d    = '0;
        timeout_d = 1'b0;
`endif
        mine  = (state_q == GNT1) ? req1 : req0;
        other = (state_q == GNT1) ? req0 : req1;
        case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = owner_q ? GNT0 : GNT1;
                else if (req0)
                    state_d = GNT0;
                else if (req1)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (!mine)
                    state_d = other ? ((state_q == GNT0) ? GNT1 : GNT0) : IDLE;
`ifdef MUTEX_TIMEOUT_EN
                else if (other) begin
                    if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0 && state_q != GNT0) begin
            owner_d = 1'b0;
            gcnt0_d = gcnt0_q + 1'b1;
        end
        if (state_d == GNT1 && state_q != GNT1) begin
            owner_d = 1'b1;
            gcnt1_d = gcnt1_q + 1'b1;
        end
    end

    // State registers; reset forces IDLE with owner=1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

`ifdef MUTEX_TIMEOUT_EN
    // Hold counter and one-cycle timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_evt = timeout_q;
`else
    assign timeout_evt = 1'b0;
`endif

    assign grant0 = (state_q == GNT0);
    assign grant1 = (state_q == GNT1);
    assign busy   = grant0 | grant1;
    assign owner  = owner_q;
    assign gcnt0  = gcnt0_q;
    assign gcnt1  = gcnt1_q;
endmodule

// File: tb/tb_mutex_arb.sv
// tb_mutex_arb: directed bench for mutex_arb with a per-cycle reference model.
module tb_mutex_arb;
    localparam int CNT_W    = 8;
    localparam int HOLD_MAX = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic             grant0, grant1, busy, owner, timeout_evt;
    logic [CNT_W-1:0] gcnt0, gcnt1;

    int n_cmp = 0;
    int n_bad = 0;

    mutex_arb #(.CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .grant0(grant0), .grant1(grant1), .busy(busy), .owner(owner),
        .gcnt0(gcnt0), .gcnt1(gcnt1), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    // Model: g = index currently granted (-1 none), counts kept as plain ints.
    typedef struct packed {
        int g;
        int own;
        int c0;
        int c1;
        int hold;
        bit tev;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(mstate_t s, bit r0, bit r1);
        mstate_t n;
        bit      r[2];
        r[0]  = r0;
        r[1]  = r1;
        n     = s;
        n.tev = 1'b0;
        if (s.g < 0)
            n.g = (r0 && r1) ? 1 - s.own : r0 ? 0 : r1 ? 1 : -1;
        else if (!r[s.g])
            n.g = r[1 - s.g] ? 1 - s.g : -1;
`ifdef MUTEX_TIMEOUT_EN
        else if (r[1 - s.g] && s.hold + 1 >= HOLD_MAX) begin
            n.g   = -1;
            n.tev = 1'b1;
        end
`endif
        n.hold = (n.g >= 0 && n.g == s.g && r[1 - n.g]) ? s.hold + 1 : 0;
        if (n.g >= 0 && n.g != s.g) begin
            n.own = n.g;
            if (n.g == 0) n.c0 = (s.c0 + 1) % (1 << CNT_W);
            else          n.c1 = (s.c1 + 1) % (1 << CNT_W);
        end
        return n;
    endfunction

    // Model advances on the same edges as the design, with the same async reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{g: -1, own: 1, c0: 0, c1: 0, hold: 0, tev: 1'b0};
        else        m <= step(m, req0, req1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle: all outputs against the model, plus mutual exclusion.
    always @(negedge clk) begin
        chk("m_grant0", int'(grant0), int'(m.g == 0));
        chk("m_grant1", int'(grant1), int'(m.g == 1));
        chk("m_busy", int'(busy), int'(m.g >= 0));
        chk("m_owner", int'(owner), m.own);
        chk("m_gcnt0", int'(gcnt0), m.c0);
        chk("m_gcnt1", int'(gcnt1), m.c1);
        chk("m_timeout", int'(timeout_evt), int'(m.tev));
        chk("m_exclusive", int'(grant0 & grant1), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end");
        $fatal(1);
    end

    initial begin
        int n;
        int d;
        // Reset values and single request latency
        tick();
        @(negedge clk);
        chk("rst_owner", int'(owner), 1);
        chk("rst_busy", int'(busy), 0);
        do_reset();
        req0 = 1'b1;
        tick();
        @(negedge clk);
        chk("single_grant0", int'(grant0), 1);
        chk("single_gcnt0", int'(gcnt0), 1);
        chk("single_owner", int'(owner), 0);
        tick();
        req0 = 1'b0;
        tick();
        // Tie after reset goes to requester 0, then direct handoff to 1
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        @(negedge clk);
        chk("tie_grant0", int'(grant0), 1);
        chk("tie_grant1", int'(grant1), 0);
        tick();
        req0 = 1'b0;
        tick();
        @(negedge clk);
        chk("handoff_grant1", int'(grant1), 1);
        chk("handoff_grant0", int'(grant0), 0);
        chk("handoff_gcnt1", int'(gcnt1), 1);
        tick();
        req1 = 1'b0;
        tick();
        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            req0 = 1'b1;
            tick();
            req0 = 1'b0;
            tick();
        end
        chk("wrap_255", int'(gcnt0), 255);
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        chk("wrap_0", int'(gcnt0), 0);
        // Closed loop: req0 driven after posedge, req1 on negedge
        do_reset();
        fork
            repeat (200) begin
                @(posedge clk);
                #1;
                req0 = !grant0;
            end
            repeat (200) begin
                @(negedge clk);
                req1 = !grant1;
            end
        join
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        d = (int'(gcnt0) - int'(gcnt1)) & 8'hff;
        chk("loop_balance", int'(d == 0 || d == 1 || d == 255), 1);
        chk("loop_grants", int'(gcnt0 > 50), 1);
        // Async reset during grant1
        do_reset();
        req1 = 1'b1;
        tick();
        @(negedge clk);
        chk("pre_rst_grant1", int'(grant1), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_grant1", int'(grant1), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_owner", int'(owner), 1);
        chk("async_gcnt1", int'(gcnt1), 0);
        req1 = 1'b0;
        tick();
        reset = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_tie", int'(grant0), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        // Hold while other side waits
        do_reset();
        req0 = 1'b1;
        tick();
        req1 = 1'b1;
`ifdef MUTEX_TIMEOUT_EN
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (!grant0) break;
            n++;
        end
        chk("to_hold_cycles", n, HOLD_MAX);
        chk("to_pulse", int'(timeout_evt), 1);
        @(negedge clk);
        chk("to_grant1", int'(grant1), 1);
        chk("to_pulse_end", int'(timeout_evt), 0);
`else
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (grant0) n++;
        end
        chk("hold_cycles", n, 30);
        chk("hold_no_timeout", int'(timeout_evt), 0);
`endif
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
